// File: rtl/pdp8_dbreak_if.sv
// Bundle of device-channel and shared-memory-port signals for the pdp8_dbreak
// data-break engine; master is the engine, slave is the devices plus RAM.
interface pdp8_dbreak_if #(
  parameter int NCH  = 2,
  parameter int MA_W = 15
);
  logic [NCH-1:0]          ch_req;
  logic [NCH-1:0]          ch_dir;
  logic [NCH-1:0]          ch_single;
  logic [NCH*12-1:0]       ch_wc_addr;
  logic [NCH*(MA_W-12)-1:0] ch_field;
  logic [NCH*12-1:0]       ch_addr;
  logic [NCH*12-1:0]       ch_data_in;
  logic [NCH-1:0]          ch_ack;
  logic [NCH-1:0]          ch_wc_zero;
  logic [11:0]             data_out;
  logic                    busy;
  logic                    ram_read_req;
  logic                    ram_write_req;
  logic                    ram_done;
  logic [MA_W-1:0]         ram_ma;
  logic [11:0]             ram_out;
  logic [11:0]             ram_in;

  modport master (
    input  ch_req, ch_dir, ch_single, ch_wc_addr, ch_field, ch_addr, ch_data_in,
    input  ram_done, ram_in,
    output ch_ack, ch_wc_zero, data_out, busy,
    output ram_read_req, ram_write_req, ram_ma, ram_out
  );

  modport slave (
    output ch_req, ch_dir, ch_single, ch_wc_addr, ch_field, ch_addr, ch_data_in,
    output ram_done, ram_in,
    input  ch_ack, ch_wc_zero, data_out, busy,
    input  ram_read_req, ram_write_req, ram_ma, ram_out
  );
endinterface

// File: rtl/pdp8_dbreak.sv
// Multi-channel PDP-8 data-break engine: arbitrates device channels onto one
// memory port and runs the WC/CA three-cycle break or a single-cycle break.
module pdp8_dbreak #(
  parameter int NCH    = 2,
  parameter int MA_W   = 15,
  parameter int ARB_RR = 0
) (
  input  logic          clk,
  input  logic          reset,
  pdp8_dbreak_if.master bus
);
  localparam int FW = MA_W - 12;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [FW-1:0] FIELD0 = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WC_RD = 3'd1,
    S_WC_WR = 3'd2,
    S_CA_RD = 3'd3,
    S_CA_WR = 3'd4,
    S_DATA  = 3'd5,
    S_ACK   = 3'd6
  } state_t;

  state_t          state_q;
  logic            done_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   ptr_q;
  logic            dir_q;
  logic            single_q;
  logic            wc_zero_q;
  logic [11:0]     wc_addr_q;
  logic [11:0]     addr_q;
  logic [11:0]     data_in_q;
  logic [11:0]     wc_q;
  logic [11:0]     ca_q;
  logic [FW-1:0]   field_q;
  logic [MA_W-1:0] ma_q;
  logic [11:0]     out_q;
  logic            rd_q;
  logic            wr_q;
  logic            busy_q;
  logic [NCH-1:0]  ack_q;
  logic [NCH-1:0]  wcz_q;
  logic [11:0]     data_out_q;

  logic            gnt_valid_d;
  logic [IW-1:0]   gnt_idx_d;
  logic [IW-1:0]   ptr_d;
  logic [IW-1:0]   scan_idx;
  int              scan_sum;
  logic            sel_dir_d;
  logic            sel_single_d;
  logic [11:0]     sel_wc_addr_d;
  logic [11:0]     sel_addr_d;
  logic [11:0]     sel_data_d;
  logic [FW-1:0]   sel_field_d;
  logic [NCH-1:0]  idx_onehot_d;

  // Scan requesters from the start point downwards so the last hit wins;
  // fixed priority is simply a scan that always starts at channel 0.
  always_comb begin
    gnt_valid_d = 1'b0;
    gnt_idx_d   = '0;
    scan_sum    = 0;
    scan_idx    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      scan_sum    = ((ARB_RR != 0) ? int'(ptr_q) : 0) + k;
      scan_idx    = IW'((scan_sum >= NCH) ? scan_sum - NCH : scan_sum);
      gnt_valid_d = gnt_valid_d | bus.ch_req[scan_idx];
      gnt_idx_d   = bus.ch_req[scan_idx] ? scan_idx : gnt_idx_d;
    end
    ptr_d = (int'(gnt_idx_d) + 1 >= NCH) ? '0 : gnt_idx_d + IW'(1);
  end

  // Mux the candidate channel's parameters for latching at grant time.
  always_comb begin
    sel_dir_d     = bus.ch_dir[gnt_idx_d];
    sel_single_d  = bus.ch_single[gnt_idx_d];
    sel_wc_addr_d = bus.ch_wc_addr[int'(gnt_idx_d) * 12 +: 12];
    sel_addr_d    = bus.ch_addr[int'(gnt_idx_d) * 12 +: 12];
    sel_data_d    = bus.ch_data_in[int'(gnt_idx_d) * 12 +: 12];
    sel_field_d   = bus.ch_field[int'(gnt_idx_d) * FW +: FW];
    idx_onehot_d  = '0;
    idx_onehot_d[idx_q] = 1'b1;
  end

  // Break sequencer. Every memory state launches its request on entry,
  // waits for ram_done, then spends one gap cycle (done_q) before the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      idx_q      <= '0;
      ptr_q      <= '0;
      dir_q      <= 1'b0;
      single_q   <= 1'b0;
      wc_zero_q  <= 1'b0;
      wc_addr_q  <= 12'd0;
      addr_q     <= 12'd0;
      data_in_q  <= 12'd0;
      wc_q       <= 12'd0;
      ca_q       <= 12'd0;
      field_q    <= '0;
      ma_q       <= '0;
      out_q      <= 12'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      wcz_q      <= '0;
      data_out_q <= 12'd0;
    end else begin
      ack_q <= '0;
      wcz_q <= '0;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (gnt_valid_d) begin
            idx_q     <= gnt_idx_d;
            dir_q     <= sel_dir_d;
            single_q  <= sel_single_d;
            wc_addr_q <= sel_wc_addr_d;
            field_q   <= sel_field_d;
            addr_q    <= sel_addr_d;
            data_in_q <= sel_data_d;
            wc_zero_q <= 1'b0;
            busy_q    <= 1'b1;
            if (ARB_RR != 0) begin
              ptr_q <= ptr_d;
            end
            if (sel_single_d) begin
              state_q <= S_DATA;
              ma_q    <= {sel_field_d, sel_addr_d};
              rd_q    <= sel_dir_d;
              wr_q    <= ~sel_dir_d;
              out_q   <= sel_data_d;
            end else begin
              state_q <= S_WC_RD;
              ma_q    <= {FIELD0, sel_wc_addr_d};
              rd_q    <= 1'b1;
              wr_q    <= 1'b0;
            end
          end
        end
        S_WC_RD, S_WC_WR, S_CA_RD, S_CA_WR: begin
          if (!done_q) begin
            if (bus.ram_done) begin
              rd_q   <= 1'b0;
              wr_q   <= 1'b0;
              done_q <= 1'b1;
              if (state_q == S_WC_RD) begin
                wc_q      <= bus.ram_in + 12'd1;
                wc_zero_q <= (bus.ram_in == 12'o7777);
              end
              if (state_q == S_CA_RD) begin
                ca_q <= bus.ram_in + 12'd1;
              end
            end
          end else begin
            done_q <= 1'b0;
            // The write-back cycles reuse ram_ma from the preceding read.
            case (state_q)
              S_WC_RD: begin
                state_q <= S_WC_WR;
                wr_q    <= 1'b1;
                out_q   <= wc_q;
              end
              S_WC_WR: begin
                state_q <= S_CA_RD;
                ma_q    <= {FIELD0, wc_addr_q + 12'd1};
                rd_q    <= 1'b1;
              end
              S_CA_RD: begin
                state_q <= S_CA_WR;
                wr_q    <= 1'b1;
                out_q   <= ca_q;
              end
              S_CA_WR: begin
                state_q <= S_DATA;
                ma_q    <= {field_q, ca_q};
                rd_q    <= dir_q;
                wr_q    <= ~dir_q;
                out_q   <= data_in_q;
              end
              default: begin
                state_q <= S_IDLE;
              end
            endcase
          end
        end
        S_DATA: begin
          if (bus.ram_done) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= S_ACK;
            ack_q   <= idx_onehot_d;
            wcz_q   <= (wc_zero_q && !single_q) ? idx_onehot_d : '0;
            if (dir_q) begin
              data_out_q <= bus.ram_in;
            end
          end
        end
        S_ACK: begin
          // The ack cycle doubles as the post-access gap.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ch_ack        = ack_q;
  assign bus.ch_wc_zero    = wcz_q;
  assign bus.data_out      = data_out_q;
  assign bus.busy          = busy_q;
  assign bus.ram_read_req  = rd_q;
  assign bus.ram_write_req = wr_q;
  assign bus.ram_ma        = ma_q;
  assign bus.ram_out       = out_q;
endmodule

// File: tb/tb_pdp8_dbreak.sv
// Scoreboard bench for pdp8_dbreak: a fixed-priority instance with a 3-cycle RAM
// model and a round-robin instance with a 1-cycle RAM, both driven from one process.
module tb_pdp8_dbreak;
  localparam int NCH  = 2;
  localparam int MA_W = 15;
  localparam int LAT  = 3;

  typedef struct packed {
    logic [2:0]  ch;
    logic        wcz;
    logic        rd;
    logic [11:0] data;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [14:0] ma;
    logic [11:0] d;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pdp8_dbreak_if #(.NCH(NCH), .MA_W(MA_W)) a_if ();
  pdp8_dbreak_if #(.NCH(NCH), .MA_W(MA_W)) r_if ();

  pdp8_dbreak #(.NCH(NCH), .MA_W(MA_W), .ARB_RR(0)) dut_fp (.clk(clk), .reset(reset), .bus(a_if));
  pdp8_dbreak #(.NCH(NCH), .MA_W(MA_W), .ARB_RR(1)) dut_rr (.clk(clk), .reset(reset), .bus(r_if));

  int errors = 0;
  int checks = 0;
  logic [11:0] mem [0:32767];
  exp_t exp_a[$];
  exp_t exp_r[$];
  acc_t a_log[$];
  int a_total[NCH];
  int a_acks[NCH];
  int r_total[NCH];
  int r_acks[NCH];
  logic a_done = 1'b0;
  logic r_done = 1'b0;
  int a_cnt = 0;
  int a_acc_n = 0;
  logic [14:0] a_ma_lat = '0;
  logic a_bad_rw = 1'b0;
  logic a_bad_ma = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, act, exp);
    end
  endtask

  task automatic cfg(input bit rr, input int ch, input logic dir, input logic single,
                     input logic [11:0] wc_addr, input logic [2:0] field,
                     input logic [11:0] addr, input logic [11:0] data);
    if (rr) begin
      r_if.ch_dir[ch] = dir;
      r_if.ch_single[ch] = single;
      r_if.ch_wc_addr[ch*12 +: 12] = wc_addr;
      r_if.ch_field[ch*3 +: 3] = field;
      r_if.ch_addr[ch*12 +: 12] = addr;
      r_if.ch_data_in[ch*12 +: 12] = data;
    end else begin
      a_if.ch_dir[ch] = dir;
      a_if.ch_single[ch] = single;
      a_if.ch_wc_addr[ch*12 +: 12] = wc_addr;
      a_if.ch_field[ch*3 +: 3] = field;
      a_if.ch_addr[ch*12 +: 12] = addr;
      a_if.ch_data_in[ch*12 +: 12] = data;
    end
  endtask

  task automatic expect_ack(input bit rr, input int ch, input logic wcz, input logic rd,
                            input logic [11:0] data);
    exp_t e;
    e.ch = 3'(ch);
    e.wcz = wcz;
    e.rd = rd;
    e.data = data;
    if (rr) exp_r.push_back(e);
    else exp_a.push_back(e);
  endtask

  // One clock of environment: RAM models, ack monitors, device request levels.
  task automatic tick();
    exp_t e;
    acc_t acc;
    @(negedge clk);
    if (!reset) begin
      a_done = 1'b0;
      a_cnt = 0;
      a_bad_rw = 1'b0;
      a_bad_ma = 1'b0;
    end else if (a_done) begin
      a_done = 1'b0;
      check_eq("req_gap", {31'd0, a_if.ram_read_req | a_if.ram_write_req}, 32'd0);
    end else if (a_if.ram_read_req || a_if.ram_write_req) begin
      if (a_cnt == 0) a_ma_lat = a_if.ram_ma;
      if (a_if.ram_ma != a_ma_lat) a_bad_ma = 1'b1;
      if (a_if.ram_read_req && a_if.ram_write_req) a_bad_rw = 1'b1;
      a_cnt++;
      if (a_cnt == LAT) begin
        check_eq("rd_wr_excl", {31'd0, a_bad_rw}, 32'd0);
        check_eq("ma_stable", {31'd0, a_bad_ma}, 32'd0);
        acc.wr = a_if.ram_write_req;
        acc.ma = a_if.ram_ma;
        if (a_if.ram_write_req) begin
          mem[a_if.ram_ma] = a_if.ram_out;
          acc.d = a_if.ram_out;
        end else begin
          a_if.ram_in = mem[a_if.ram_ma];
          acc.d = mem[a_if.ram_ma];
        end
        a_log.push_back(acc);
        a_acc_n++;
        a_done = 1'b1;
        a_cnt = 0;
        a_bad_rw = 1'b0;
        a_bad_ma = 1'b0;
      end
    end
    a_if.ram_done = a_done;

    if (!reset) r_done = 1'b0;
    else if (r_done) r_done = 1'b0;
    else if (r_if.ram_read_req || r_if.ram_write_req) r_done = 1'b1;
    r_if.ram_done = r_done;

    for (int i = 0; i < NCH; i++) begin
      if (a_if.ch_ack[i]) begin
        a_acks[i]++;
        check_eq("fp_ack_expected", {31'd0, exp_a.size() != 0}, 32'd1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check_eq("fp_ack_ch", i, {29'd0, e.ch});
          check_eq("fp_wc_zero", {31'd0, a_if.ch_wc_zero[i]}, {31'd0, e.wcz});
          if (e.rd) check_eq("fp_data_out", {20'd0, a_if.data_out}, {20'd0, e.data});
        end
      end
      if (r_if.ch_ack[i]) begin
        r_acks[i]++;
        check_eq("rr_ack_expected", {31'd0, exp_r.size() != 0}, 32'd1);
        if (exp_r.size() != 0) begin
          e = exp_r.pop_front();
          check_eq("rr_ack_ch", i, {29'd0, e.ch});
          check_eq("rr_wc_zero", {31'd0, r_if.ch_wc_zero[i]}, {31'd0, e.wcz});
        end
      end
      a_if.ch_req[i] = (a_total[i] > a_acks[i]);
      r_if.ch_req[i] = (r_total[i] > r_acks[i]);
    end
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      ok = (exp_a.size() == 0) && (exp_r.size() == 0) && !a_if.busy && !r_if.busy;
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
    for (int i = 0; i < NCH; i++) begin
      if (a_total[i] < a_acks[i]) a_total[i] = a_acks[i];
      if (r_total[i] < r_acks[i]) r_total[i] = r_acks[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 12'd0;
    for (int i = 0; i < NCH; i++) begin
      a_total[i] = 0; a_acks[i] = 0; r_total[i] = 0; r_acks[i] = 0;
    end
    a_if.ch_req = '0; a_if.ch_dir = '0; a_if.ch_single = '0; a_if.ch_wc_addr = '0;
    a_if.ch_field = '0; a_if.ch_addr = '0; a_if.ch_data_in = '0;
    a_if.ram_done = 1'b0; a_if.ram_in = 12'd0;
    r_if.ch_req = '0; r_if.ch_dir = '0; r_if.ch_single = '0; r_if.ch_wc_addr = '0;
    r_if.ch_field = '0; r_if.ch_addr = '0; r_if.ch_data_in = '0;
    r_if.ram_done = 1'b0; r_if.ram_in = 12'd0;

    repeat (3) tick();
    check_eq("rst_busy", {31'd0, a_if.busy}, 32'd0);
    check_eq("rst_ack", {30'd0, a_if.ch_ack}, 32'd0);
    check_eq("rst_wcz", {30'd0, a_if.ch_wc_zero}, 32'd0);
    check_eq("rst_rd", {31'd0, a_if.ram_read_req}, 32'd0);
    check_eq("rst_wr", {31'd0, a_if.ram_write_req}, 32'd0);
    check_eq("rst_ma", {17'd0, a_if.ram_ma}, 32'd0);
    check_eq("rst_out", {20'd0, a_if.ram_out}, 32'd0);
    check_eq("rst_data_out", {20'd0, a_if.data_out}, 32'd0);
    reset = 1'b1;
    tick();

    // ch0 three-cycle write; request dropped and data_in changed mid-transfer.
    mem[15'o07750] = 12'o7776;
    mem[15'o07751] = 12'o0177;
    cfg(0, 0, 1'b0, 1'b0, 12'o7750, 3'd1, 12'o0000, 12'o1234);
    expect_ack(0, 0, 1'b0, 1'b0, 12'o0);
    a_total[0]++;
    repeat (4) tick();
    a_if.ch_data_in[11:0] = 12'o7070;
    a_total[0] = a_acks[0];
    run_until_idle("t1_done", 300);
    check_eq("t1_wc", {20'd0, mem[15'o07750]}, 32'o7777);
    check_eq("t1_ca", {20'd0, mem[15'o07751]}, 32'o0200);
    check_eq("t1_data", {20'd0, mem[15'o10200]}, 32'o1234);

    // ch1 read with WC and CA both wrapping to 0000.
    mem[15'o07760] = 12'o7777;
    mem[15'o07761] = 12'o7777;
    mem[15'o00000] = 12'o4321;
    cfg(0, 1, 1'b1, 1'b0, 12'o7760, 3'd0, 12'o0000, 12'o0000);
    expect_ack(0, 1, 1'b1, 1'b1, 12'o4321);
    a_total[1]++;
    run_until_idle("t2_done", 300);
    check_eq("t2_wc", {20'd0, mem[15'o07760]}, 32'o0);
    check_eq("t2_ca", {20'd0, mem[15'o07761]}, 32'o0);

    // WC word at 7777 puts CA at 0000.
    mem[15'o07777] = 12'o0005;
    mem[15'o00000] = 12'o0010;
    cfg(0, 0, 1'b0, 1'b0, 12'o7777, 3'd3, 12'o0000, 12'o0707);
    expect_ack(0, 0, 1'b0, 1'b0, 12'o0);
    a_total[0]++;
    run_until_idle("t3_done", 300);
    check_eq("t3_wc", {20'd0, mem[15'o07777]}, 32'o0006);
    check_eq("t3_ca", {20'd0, mem[15'o00000]}, 32'o0011);
    check_eq("t3_data", {20'd0, mem[15'o30011]}, 32'o0707);

    // Single-cycle write: exactly one access, no WC/CA traffic.
    a_log.delete();
    cfg(0, 0, 1'b0, 1'b1, 12'o7750, 3'd2, 12'o0300, 12'o5555);
    expect_ack(0, 0, 1'b0, 1'b0, 12'o0);
    a_total[0]++;
    run_until_idle("t4_done", 100);
    check_eq("t4_accesses", a_log.size(), 32'd1);
    if (a_log.size() != 0) begin
      check_eq("t4_ma", {17'd0, a_log[0].ma}, 32'o20300);
      check_eq("t4_is_write", {31'd0, a_log[0].wr}, 32'd1);
    end
    check_eq("t4_data", {20'd0, mem[15'o20300]}, 32'o5555);
    check_eq("t4_wc_untouched", {20'd0, mem[15'o07750]}, 32'o7777);

    // Both channels held for four grants each on both arbiters.
    for (int c = 0; c < NCH; c++) begin
      cfg(0, c, 1'b0, 1'b1, 12'o0000, 3'd0, 12'(12'o0600 + c), 12'(12'o1000 + c));
      cfg(1, c, 1'b0, 1'b1, 12'o0000, 3'd0, 12'(12'o0600 + c), 12'(12'o1000 + c));
    end
    for (int g = 0; g < 8; g++) begin
      expect_ack(0, (g < 4) ? 0 : 1, 1'b0, 1'b0, 12'o0);
      expect_ack(1, g % 2, 1'b0, 1'b0, 12'o0);
    end
    a_total[0] += 4; a_total[1] += 4;
    r_total[0] += 4; r_total[1] += 4;
    run_until_idle("arb_done", 1000);

    // Reset during CA_RD aborts with no ack.
    mem[15'o00500] = 12'o0001;
    mem[15'o00501] = 12'o0002;
    cfg(0, 0, 1'b0, 1'b0, 12'o0500, 3'd0, 12'o0000, 12'o1111);
    a_acc_n = 0;
    a_total[0]++;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (a_acc_n == 2 && a_if.ram_read_req) break;
    end
    check_eq("rst_at_ca_rd", {17'd0, a_if.ram_ma}, 32'o00501);
    reset = 1'b0;
    a_total[0] = a_acks[0];
    #1;
    check_eq("rst_mid_rd", {31'd0, a_if.ram_read_req}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, a_if.busy}, 32'd0);
    repeat (4) tick();
    check_eq("rst_mid_no_ack", {30'd0, a_if.ch_ack}, 32'd0);
    reset = 1'b1;
    tick();

    // Fresh request after the abort starts from WC_RD.
    a_log.delete();
    mem[15'o00100] = 12'o7770;
    mem[15'o00101] = 12'o0377;
    mem[15'o10400] = 12'o2222;
    cfg(0, 1, 1'b1, 1'b0, 12'o0100, 3'd1, 12'o0000, 12'o0000);
    expect_ack(0, 1, 1'b0, 1'b1, 12'o2222);
    a_total[1]++;
    run_until_idle("t6_done", 300);
    check_eq("t6_accesses", a_log.size(), 32'd5);
    if (a_log.size() != 0) begin
      check_eq("t6_first_ma", {17'd0, a_log[0].ma}, 32'o00100);
      check_eq("t6_first_rd", {31'd0, a_log[0].wr}, 32'd0);
    end
    check_eq("t6_wc", {20'd0, mem[15'o00100]}, 32'o7771);
    check_eq("t6_ca", {20'd0, mem[15'o00101]}, 32'o0400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
